id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DW, 16, datapath width (register data, immediate, PC).
REQ-002 SHALL have parameter RW, 3, register-index width.
REQ-003 SHALL have parameter CW, 16, width of the bubble counter.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as below:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have these decode-side inputs:
- id_valid  input  1  decode slot holds a real instruction.
- id_regDst, id_aluSrc, id_memtoReg, id_regWrite, id_memRead, id_memWrite, id_branch  input  1 each  control-unit outputs.
- id_aluOp  input  2  ALU operation class.
- id_read_data_1, id_read_data_2  input  DW  register-file read data.
- id_imm  input  DW  sign-extended immediate.
- id_rs, id_rt, id_rd  input  RW  source and destination register indices.
- id_uses_rt  input  1  instruction reads rt as a source.
- id_pc_plus_2  input  DW  PC+2 of the decode instruction.
REQ-006 SHALL have these pipeline-control inputs:
- flush  input  1  taken branch; kill the decode instruction.
- hold  input  1  downstream busy; freeze the stage.
REQ-007 SHALL have these outputs:
- ex_valid  output  1  registered valid bit.
- ex_regDst, ex_aluSrc, ex_memtoReg, ex_regWrite, ex_memRead, ex_memWrite, ex_branch  output  1 each  registered controls.
- ex_aluOp  output  2  registered ALU operation class.
- ex_read_data_1, ex_read_data_2, ex_imm, ex_pc_plus_2  output  DW  registered data.
- ex_rs, ex_rt, ex_rd  output  RW  registered register indices.
- stall  output  1  combinational; freeze PC and IF/ID.
- bubble_count  output  CW  count of load-use bubbles.

Function
REQ-008 SHALL compute load_use = id_valid & ex_valid & ex_memRead & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))), combinationally from the current register state.
REQ-009 SHALL drive stall = load_use | hold, with no register between inputs and stall.
REQ-010 SHALL select the next-state action at each rising clk edge with this priority: flush, then hold, then load_use, then load.
REQ-011 On flush, SHALL load a bubble: ex_valid=0, all ex_ control outputs 0, ex_aluOp=0; data and index fields SHALL be don't-care and SHALL be implemented as cleared to 0.
REQ-012 On hold without flush, SHALL keep every ex_ register and bubble_count unchanged.
REQ-013 On load_use without flush or hold, SHALL load a bubble as in REQ-011 and SHALL increment bubble_count by 1.
REQ-014 Otherwise, SHALL capture every id_ input into the matching ex_ register, with ex_valid=id_valid.
REQ-015 When id_valid=0, SHALL capture the controls as 0, so that an invalid slot never asserts ex_regWrite, ex_memWrite or ex_memRead.
REQ-016 SHALL saturate bubble_count at 2^CW-1 (0xFFFF at default), with no wrap to 0.
REQ-017 SHALL add latency of exactly one cycle from the id_ inputs to the ex_ outputs.
REQ-018 After a load_use bubble, SHALL deassert stall in the next cycle because ex_memRead=0, so each load-use hazard costs exactly one bubble.
REQ-019 With hold and load_use both active, SHALL insert no bubble and leave bubble_count unchanged; the hazard SHALL be re-evaluated after hold drops.

Reset
REQ-020 While rst_n=0, SHALL force every ex_ output to 0, ex_valid to 0 and bubble_count to 0, immediately and independent of clk.
REQ-021 During reset, stall SHALL be 0 unless hold=1.
REQ-022 On rst_n deassertion, SHALL take its first capture at the next rising clk edge.
REQ-023 An rst_n assertion mid-hold or mid-bubble SHALL discard that state with no residual effect.

Structure
REQ-024 The shared pipeline package SHALL hold the DW and RW defaults, the aluOp encodings, and a packed control-bundle typedef covering the 7 control bits plus aluOp, reused by the EX/MEM and MEM/WB stages.
REQ-025 SHALL contain one sub-module, hazard_detect (combinational load_use), for reuse by the forwarding work.

Verification
REQ-026 Reset: rst_n=0 with id_valid=1 and id_regWrite=1 driven -> all outputs 0 and ex_valid=0 immediately, before any clock edge.
REQ-027 Load-use: LW with id_rt=3 captured, next decode instruction with id_rs=3 -> stall=1 for exactly one cycle, one bubble (ex_valid=0), bubble_count=1, then the instruction is captured.
REQ-028 No hazard: LW with rt=3, next instruction with rs=2, rt=3, id_uses_rt=0 -> stall=0 and no bubble.
REQ-029 Flush vs hold: flush=1 and hold=1 in the same cycle -> next cycle ex_valid=0 and ex_regWrite=0.
REQ-030 Hold freeze: hold=1 for 3 cycles with changing id_ inputs -> ex_ outputs constant and stall=1 throughout.
REQ-031 Saturation: bubble_count preset to 0xFFFE, then 3 load-use events -> bubble_count stays at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: default widths, ALU operation classes and the
// control bundle carried from ID through EX/MEM and MEM/WB.
package id_ex_stage_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10,
    ALU_OP_IMM   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       memto_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: the instruction in EX is a load whose destination rt is
// a source of the instruction currently in decode.
module hazard_detect #(
  parameter int RW = 3
) (
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rt,
  output logic          load_use
);

  assign load_use = id_valid & ex_valid & ex_mem_read &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, hold and load-use bubble insertion,
// plus a saturating count of inserted load-use bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_regDst,
  input  logic          id_aluSrc,
  input  logic          id_memtoReg,
  input  logic          id_regWrite,
  input  logic          id_memRead,
  input  logic          id_memWrite,
  input  logic          id_branch,
  input  logic [1:0]    id_aluOp,
  input  logic [DW-1:0] id_read_data_1,
  input  logic [DW-1:0] id_read_data_2,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_uses_rt,
  input  logic [DW-1:0] id_pc_plus_2,
  input  logic          flush,
  input  logic          hold,
  output logic          ex_valid,
  output logic          ex_regDst,
  output logic          ex_aluSrc,
  output logic          ex_memtoReg,
  output logic          ex_regWrite,
  output logic          ex_memRead,
  output logic          ex_memWrite,
  output logic          ex_branch,
  output logic [1:0]    ex_aluOp,
  output logic [DW-1:0] ex_read_data_1,
  output logic [DW-1:0] ex_read_data_2,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc_plus_2,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic          stall,
  output logic [CW-1:0] bubble_count
);

  ctrl_t         id_ctrl;
  ctrl_t         ctrl_reg, ctrl_next;
  logic          valid_reg, valid_next;
  logic [DW-1:0] rd1_reg, rd1_next, rd2_reg, rd2_next;
  logic [DW-1:0] imm_reg, imm_next, pc_reg, pc_next;
  logic [RW-1:0] rs_reg, rs_next, rt_reg, rt_next, rd_reg, rd_next;
  logic [CW-1:0] bubble_count_reg, bubble_count_next;
  logic          load_use;

  assign id_ctrl = {id_regDst, id_aluSrc, id_memtoReg, id_regWrite,
                    id_memRead, id_memWrite, id_branch, id_aluOp};

  hazard_detect #(.RW(RW)) u_hazard_detect (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_valid    (valid_reg),
    .ex_mem_read (ctrl_reg.mem_read),
    .ex_rt       (rt_reg),
    .load_use    (load_use)
  );

  assign stall = load_use | hold;

  always_comb begin
    valid_next        = valid_reg;
    ctrl_next         = ctrl_reg;
    rd1_next          = rd1_reg;
    rd2_next          = rd2_reg;
    imm_next          = imm_reg;
    pc_next           = pc_reg;
    rs_next           = rs_reg;
    rt_next           = rt_reg;
    rd_next           = rd_reg;
    bubble_count_next = bubble_count_reg;
    if (flush || (!hold && load_use)) begin
      valid_next = 1'b0;
      ctrl_next  = '0;
      rd1_next   = '0;
      rd2_next   = '0;
      imm_next   = '0;
      pc_next    = '0;
      rs_next    = '0;
      rt_next    = '0;
      rd_next    = '0;
      // Only hazard bubbles are counted, and the count sticks at all-ones.
      if (!flush && (bubble_count_reg != '1))
        bubble_count_next = bubble_count_reg + CW'(1);
    end else if (!hold) begin
      valid_next = id_valid;
      ctrl_next  = id_valid ? id_ctrl : '0;
      rd1_next   = id_read_data_1;
      rd2_next   = id_read_data_2;
      imm_next   = id_imm;
      pc_next    = id_pc_plus_2;
      rs_next    = id_rs;
      rt_next    = id_rt;
      rd_next    = id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg        <= 1'b0;
      ctrl_reg         <= '0;
      rd1_reg          <= '0;
      rd2_reg          <= '0;
      imm_reg          <= '0;
      pc_reg           <= '0;
      rs_reg           <= '0;
      rt_reg           <= '0;
      rd_reg           <= '0;
      bubble_count_reg <= '0;
    end else begin
      valid_reg        <= valid_next;
      ctrl_reg         <= ctrl_next;
      rd1_reg          <= rd1_next;
      rd2_reg          <= rd2_next;
      imm_reg          <= imm_next;
      pc_reg           <= pc_next;
      rs_reg           <= rs_next;
      rt_reg           <= rt_next;
      rd_reg           <= rd_next;
      bubble_count_reg <= bubble_count_next;
    end
  end

  assign ex_valid       = valid_reg;
  assign ex_regDst      = ctrl_reg.reg_dst;
  assign ex_aluSrc      = ctrl_reg.alu_src;
  assign ex_memtoReg    = ctrl_reg.memto_reg;
  assign ex_regWrite    = ctrl_reg.reg_write;
  assign ex_memRead     = ctrl_reg.mem_read;
  assign ex_memWrite    = ctrl_reg.mem_write;
  assign ex_branch      = ctrl_reg.branch;
  assign ex_aluOp       = ctrl_reg.alu_op;
  assign ex_read_data_1 = rd1_reg;
  assign ex_read_data_2 = rd2_reg;
  assign ex_imm         = imm_reg;
  assign ex_pc_plus_2   = pc_reg;
  assign ex_rs          = rs_reg;
  assign ex_rt          = rt_reg;
  assign ex_rd          = rd_reg;
  assign bubble_count   = bubble_count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of captured instructions plus
// direct checks of stall, bubbles, hold, flush, reset and counter saturation.
module tb_id_ex_stage;

  localparam int VW = 82;

  logic clk, rst_n;
  logic id_valid, id_regDst, id_aluSrc, id_memtoReg, id_regWrite;
  logic id_memRead, id_memWrite, id_branch, id_uses_rt;
  logic [1:0] id_aluOp;
  logic [15:0] id_read_data_1, id_read_data_2, id_imm, id_pc_plus_2;
  logic [2:0] id_rs, id_rt, id_rd;
  logic flush, hold;

  logic ex_valid, ex_regDst, ex_aluSrc, ex_memtoReg, ex_regWrite;
  logic ex_memRead, ex_memWrite, ex_branch, stall;
  logic [1:0] ex_aluOp;
  logic [15:0] ex_read_data_1, ex_read_data_2, ex_imm, ex_pc_plus_2, bubble_count;
  logic [2:0] ex_rs, ex_rt, ex_rd;

  // Second instance with a 2-bit counter so saturation is reachable quickly.
  logic s_valid, s_regDst, s_aluSrc, s_memtoReg, s_regWrite;
  logic s_memRead, s_memWrite, s_branch, s_stall;
  logic [1:0] s_aluOp, s_count;
  logic [15:0] s_rd1, s_rd2, s_imm, s_pc;
  logic [2:0] s_rs, s_rt, s_rd;

  int checks = 0;
  int failures = 0;
  logic [VW-1:0] exp_q[$];

  typedef struct {
    logic valid, reg_dst, alu_src, memto_reg, reg_write, mem_read, mem_write, branch, uses_rt;
    logic [1:0] alu_op;
    logic [15:0] rd1, rd2, imm, pc;
    logic [2:0] rs, rt, rd;
  } ins_t;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_regDst(id_regDst),
    .id_aluSrc(id_aluSrc), .id_memtoReg(id_memtoReg), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_branch(id_branch),
    .id_aluOp(id_aluOp), .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_pc_plus_2(id_pc_plus_2), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_regDst(ex_regDst), .ex_aluSrc(ex_aluSrc),
    .ex_memtoReg(ex_memtoReg), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_branch(ex_branch), .ex_aluOp(ex_aluOp),
    .ex_read_data_1(ex_read_data_1), .ex_read_data_2(ex_read_data_2), .ex_imm(ex_imm),
    .ex_pc_plus_2(ex_pc_plus_2), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall(stall), .bubble_count(bubble_count)
  );

  id_ex_stage #(.CW(2)) sat_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_regDst(id_regDst),
    .id_aluSrc(id_aluSrc), .id_memtoReg(id_memtoReg), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_branch(id_branch),
    .id_aluOp(id_aluOp), .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_pc_plus_2(id_pc_plus_2), .flush(flush), .hold(hold),
    .ex_valid(s_valid), .ex_regDst(s_regDst), .ex_aluSrc(s_aluSrc),
    .ex_memtoReg(s_memtoReg), .ex_regWrite(s_regWrite), .ex_memRead(s_memRead),
    .ex_memWrite(s_memWrite), .ex_branch(s_branch), .ex_aluOp(s_aluOp),
    .ex_read_data_1(s_rd1), .ex_read_data_2(s_rd2), .ex_imm(s_imm),
    .ex_pc_plus_2(s_pc), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .stall(s_stall), .bubble_count(s_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic ins_t mk(logic v, logic mr, logic mw, logic rw, logic [2:0] rs,
                              logic [2:0] rt, logic [2:0] rd, logic ut, logic [15:0] pc);
    ins_t m;
    m.valid = v; m.mem_read = mr; m.mem_write = mw; m.reg_write = rw;
    m.reg_dst = rw & ~mr; m.alu_src = mr | mw; m.memto_reg = mr;
    m.branch = (pc[3:0] == 4'h6);
    m.alu_op = (mr | mw) ? 2'b00 : pc[2:1];
    m.rd1 = pc * 16'd3 + 16'h0101;
    m.rd2 = ~pc;
    m.imm = {pc[7:0], pc[15:8]} ^ 16'h00F0;
    m.pc = pc; m.rs = rs; m.rt = rt; m.rd = rd; m.uses_rt = ut;
    return m;
  endfunction

  function automatic logic [VW-1:0] vec_of(ins_t m);
    return {m.reg_dst, m.alu_src, m.memto_reg, m.reg_write, m.mem_read, m.mem_write,
            m.branch, m.alu_op, m.rd1, m.rd2, m.imm, m.pc, m.rs, m.rt, m.rd};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {ex_regDst, ex_aluSrc, ex_memtoReg, ex_regWrite, ex_memRead, ex_memWrite,
            ex_branch, ex_aluOp, ex_read_data_1, ex_read_data_2, ex_imm, ex_pc_plus_2,
            ex_rs, ex_rt, ex_rd};
  endfunction

  task automatic drive(ins_t m);
    id_valid = m.valid; id_regDst = m.reg_dst; id_aluSrc = m.alu_src;
    id_memtoReg = m.memto_reg; id_regWrite = m.reg_write; id_memRead = m.mem_read;
    id_memWrite = m.mem_write; id_branch = m.branch; id_aluOp = m.alu_op;
    id_read_data_1 = m.rd1; id_read_data_2 = m.rd2; id_imm = m.imm;
    id_pc_plus_2 = m.pc; id_rs = m.rs; id_rt = m.rt; id_rd = m.rd; id_uses_rt = m.uses_rt;
  endtask

  task automatic check(string name, logic [VW-1:0] got, logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else begin
      $display("check %s ok value=%0h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: after each edge that captured (no reset, flush or stall), a
  // valid EX output must match the oldest queued expectation.
  initial begin
    logic cap;
    logic [VW-1:0] exp_v;
    forever begin
      @(posedge clk);
      cap = rst_n && !flush && !stall;
      @(negedge clk);
      if (cap && ex_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_unexpected got=%0h exp=none", dut_vec());
        end else begin
          exp_v = exp_q.pop_front();
          if (dut_vec() !== exp_v) begin
            failures++;
            $display("FAIL mon_capture got=%0h exp=%0h", dut_vec(), exp_v);
          end else begin
            $display("mon capture pc=%0h ok", ex_pc_plus_2);
          end
        end
      end
    end
  end

  initial begin
    ins_t a, b;
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
    drive(mk(1, 0, 0, 1, 1, 2, 3, 1, 16'h0004));
    #1;
    check("rst_valid", VW'(ex_valid), 0);
    check("rst_regwrite", VW'(ex_regWrite), 0);
    check("rst_outputs", dut_vec(), 0);
    check("rst_count", VW'(bubble_count), 0);
    check("rst_stall", VW'(stall), 0);
    hold = 1'b1; #1;
    check("rst_stall_hold", VW'(stall), 1);
    hold = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
    rst_n = 1'b1;
    step();
    check("first_idle_valid", VW'(ex_valid), 0);

    // Load-use on rs
    a = mk(1, 1, 0, 1, 1, 3, 0, 0, 16'h0010);
    drive(a); #1;
    check("lw1_stall", VW'(stall), 0);
    exp_q.push_back(vec_of(a));
    step();
    b = mk(1, 0, 0, 1, 3, 4, 5, 1, 16'h0012);
    drive(b); #1;
    check("lu1_stall", VW'(stall), 1);
    step();
    check("lu1_bubble", VW'(ex_valid), 0);
    check("lu1_count", VW'(bubble_count), 1);
    check("lu1_stall_drop", VW'(stall), 0);
    exp_q.push_back(vec_of(b));
    step();
    check("lu1_count_after", VW'(bubble_count), 1);

    // No hazard: rt matches but is not read
    a = mk(1, 1, 0, 1, 0, 3, 0, 0, 16'h0020);
    drive(a); exp_q.push_back(vec_of(a));
    step();
    b = mk(1, 0, 0, 1, 2, 3, 6, 0, 16'h0022);
    drive(b); #1;
    check("nohaz_stall", VW'(stall), 0);
    exp_q.push_back(vec_of(b));
    step();
    check("nohaz_count", VW'(bubble_count), 1);

    // Load-use on rt
    a = mk(1, 1, 0, 1, 1, 5, 0, 0, 16'h0030);
    drive(a); exp_q.push_back(vec_of(a));
    step();
    b = mk(1, 0, 1, 0, 0, 5, 0, 1, 16'h0032);
    drive(b); #1;
    check("lu2_stall", VW'(stall), 1);
    step();
    check("lu2_bubble", VW'(ex_valid), 0);
    check("lu2_count", VW'(bubble_count), 2);
    check("sat_count_2", VW'(s_count), 2);
    exp_q.push_back(vec_of(b));
    step();

    // Invalid slot with asserted controls and matching rs
    a = mk(1, 1, 0, 1, 2, 6, 0, 0, 16'h0040);
    drive(a); exp_q.push_back(vec_of(a));
    step();
    drive(mk(0, 1, 1, 1, 6, 6, 1, 1, 16'h0042)); #1;
    check("inv_stall", VW'(stall), 0);
    step();
    check("inv_ctrls", VW'({ex_valid, ex_regWrite, ex_memWrite, ex_memRead}), 0);
    check("inv_count", VW'(bubble_count), 2);

    // Flush and hold together
    a = mk(1, 0, 0, 1, 1, 2, 3, 1, 16'h0050);
    drive(a); exp_q.push_back(vec_of(a));
    step();
    drive(mk(1, 0, 0, 1, 1, 2, 3, 1, 16'h0052));
    flush = 1'b1; hold = 1'b1; #1;
    check("fh_stall", VW'(stall), 1);
    step();
    flush = 1'b0; hold = 1'b0;
    check("fh_valid_regwrite", VW'({ex_valid, ex_regWrite}), 0);
    check("fh_count", VW'(bubble_count), 2);

    // Hold freeze with changing inputs
    a = mk(1, 1, 0, 1, 4, 7, 0, 0, 16'h0060);
    drive(a); exp_q.push_back(vec_of(a));
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 0, 0, 1, 3'(i), 3'(i + 1), 3'(i + 2), 1, 16'h0070 + 16'(2 * i)));
      #1;
      check("hold_stall", VW'(stall), 1);
      step();
      check("hold_frozen", {ex_valid, dut_vec()}, {1'b1, vec_of(a)});
    end

    // Hold masks a pending load-use; bubble after hold drops
    b = mk(1, 0, 0, 1, 7, 0, 1, 0, 16'h0080);
    drive(b); #1;
    check("hlu_stall", VW'(stall), 1);
    step();
    check("hlu_frozen", dut_vec(), vec_of(a));
    step();
    check("hlu_count_held", VW'(bubble_count), 2);
    hold = 1'b0; #1;
    check("hlu_stall_after", VW'(stall), 1);
    step();
    check("hlu_bubble", VW'(ex_valid), 0);
    check("hlu_count", VW'(bubble_count), 3);
    check("sat_count_3", VW'(s_count), 3);
    exp_q.push_back(vec_of(b));
    step();

    // Two more hazards: wide counter keeps counting, narrow one saturates
    for (int k = 0; k < 2; k++) begin
      a = mk(1, 1, 0, 1, 0, 2, 0, 0, 16'h0090 + 16'(4 * k));
      drive(a); exp_q.push_back(vec_of(a));
      step();
      b = mk(1, 0, 0, 1, 2, 0, 3, 0, 16'h0092 + 16'(4 * k));
      drive(b);
      step();
      check("extra_count", VW'(bubble_count), VW'(4 + k));
      check("sat_hold_max", VW'(s_count), 3);
      exp_q.push_back(vec_of(b));
      step();
    end

    // Reset asserted mid-hold with a pending hazard
    a = mk(1, 1, 0, 1, 0, 1, 0, 0, 16'h00A0);
    drive(a); exp_q.push_back(vec_of(a));
    step();
    b = mk(1, 0, 0, 1, 1, 0, 2, 0, 16'h00A2);
    drive(b); hold = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {ex_valid, dut_vec()}, 0);
    check("mid_rst_count", VW'({bubble_count, s_count}), 0);
    check("mid_rst_stall_hold", VW'(stall), 1);
    hold = 1'b0; #1;
    check("mid_rst_stall", VW'(stall), 0);
    exp_q.push_back(vec_of(b));
    rst_n = 1'b1;
    step();
    check("post_rst_count", VW'(bubble_count), 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
    step();
    step();
    check("queue_drained", VW'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
